// File: rtl/word_scroll_ctrl.sv
`timescale 1ns/1ps
// Scroll controller: holds a short ASCII message and presents a wrapping DIGITS-wide
// window of it, one byte per seven-segment word decoder, stepping at a fixed tick rate.
module word_scroll_ctrl #(
  parameter int MSG_DEPTH = 16,
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 25000000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                WrEn,
  input  logic [7:0]          WrChar,
  input  logic                Clear,
  input  logic                Start,
  input  logic                Stop,
  input  logic                Pause,
  output logic [8*DIGITS-1:0] Chars,
  output logic                Busy,
  output logic                Full,
  output logic                Wrap
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int OW = $clog2(MSG_DEPTH + DIGITS);
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = OW + 1;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {IDLE = 1'b0, SCROLL = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          msg_reg [0:MSG_DEPTH-1];
  logic [LW-1:0]       len_reg, len_next;
  logic [OW-1:0]       ofs_reg, ofs_next;
  logic [TW-1:0]       tick_reg, tick_next;
  logic [8*DIGITS-1:0] chars_reg, chars_next;
  logic                busy_reg, busy_next;
  logic                full_reg, full_next;
  logic                wrap_reg, wrap_next;
  logic                wr_accept, start_ok, tick_done;
  logic [SW-1:0]       p_len, p_last;

  // Virtual stream length: the message followed by one window of trailing spaces.
  assign p_len     = SW'(len_reg) + SW'(DIGITS);
  assign p_last    = p_len - SW'(1);
  assign wr_accept = (state_reg == IDLE) && WrEn && !Clear && !full_reg;
  assign start_ok  = (state_reg == IDLE) && Start && !Clear && (len_reg != '0);
  assign tick_done = (tick_reg == TW'(TICK_DIV - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      ofs_reg   <= '0;
      tick_reg  <= '0;
      chars_reg <= {DIGITS{SPACE}};
      busy_reg  <= 1'b0;
      full_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      ofs_reg   <= ofs_next;
      tick_reg  <= tick_next;
      chars_reg <= chars_next;
      busy_reg  <= busy_next;
      full_reg  <= full_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Message storage needs no reset; only entries below len_reg are ever shown.
  always_ff @(posedge Clk) begin
    if (wr_accept) begin
      msg_reg[len_reg[AW-1:0]] <= WrChar;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start_ok) state_next = SCROLL;
      SCROLL: if (Stop)     state_next = IDLE;
    endcase
  end

  always_comb begin
    len_next  = len_reg;
    ofs_next  = ofs_reg;
    tick_next = tick_reg;
    wrap_next = 1'b0;
    case (state_reg)
      IDLE: begin
        ofs_next  = '0;
        tick_next = '0;
        if (Clear) begin
          len_next = '0;
        end else if (wr_accept) begin
          len_next = len_reg + LW'(1);
        end
      end
      SCROLL: begin
        // Stop discards any same-cycle step; Pause freezes tick and offset.
        if (!Stop && !Pause) begin
          if (tick_done) begin
            tick_next = '0;
            if (SW'(ofs_reg) == p_last) begin
              ofs_next  = '0;
              wrap_next = 1'b1;
            end else begin
              ofs_next = ofs_reg + OW'(1);
            end
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
      end
    endcase
    busy_next = (state_next == SCROLL);
    full_next = (len_next == LW'(MSG_DEPTH));
  end

  // Window built from next-cycle offset so Chars moves on the same edge as Ofs.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [SW-1:0] sum;
      logic [SW-1:0] idx;
      logic [7:0]    digit_next;
      always_comb begin
        sum        = SW'(ofs_next) + SW'(gi);
        idx        = (sum >= p_len) ? (sum - p_len) : sum;
        digit_next = SPACE;
        if ((state_next == SCROLL) && (idx < SW'(len_reg))) begin
          digit_next = msg_reg[idx[AW-1:0]];
        end
      end
      assign chars_next[8*(DIGITS-1-gi) +: 8] = digit_next;
    end
  endgenerate

  assign Chars = chars_reg;
  assign Busy  = busy_reg;
  assign Full  = full_reg;
  assign Wrap  = wrap_reg;

endmodule

// File: tb/tb_word_scroll_ctrl.sv
`timescale 1ns/1ps
// Bench for word_scroll_ctrl: scenario tasks checked against a message-queue model
// whose window offset is derived from the count of active scroll cycles.
module tb_word_scroll_ctrl;

  localparam int DEPTH = 16;
  localparam int DIG   = 4;
  localparam int TDIV  = 4;
  localparam logic [31:0] BLANK = 32'h20202020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_char = 8'h00;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [31:0] chars;
  logic        busy, full, wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: message queue, scrolling flag, count of non-paused scroll cycles.
  logic [7:0] msg_q[$];
  bit         m_busy = 1'b0;
  int         act = 0;
  bit         m_wrap = 1'b0;

  word_scroll_ctrl #(.MSG_DEPTH(DEPTH), .DIGITS(DIG), .TICK_DIV(TDIV)) dut (
    .Clk(clk), .Rst_n(rst_n), .WrEn(wr_en), .WrChar(wr_char), .Clear(clear),
    .Start(start), .Stop(stop), .Pause(pause), .Chars(chars), .Busy(busy),
    .Full(full), .Wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_chars();
    logic [31:0] r;
    int p, ofs, j;
    r = BLANK;
    if (m_busy) begin
      p   = msg_q.size() + DIG;
      ofs = (act / TDIV) % p;
      for (int k = 0; k < DIG; k++) begin
        j = (ofs + k) % p;
        r[31-8*k -: 8] = (j < msg_q.size()) ? msg_q[j] : 8'h20;
      end
    end
    return r;
  endfunction

  function automatic bit model_full();
    return msg_q.size() == DEPTH;
  endfunction

  task automatic model_reset();
    msg_q.delete();
    m_busy = 1'b0;
    act    = 0;
    m_wrap = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs sampled on it.
  task automatic cycle();
    bit start_ok;
    int p;
    start_ok = !m_busy && start && !clear && (msg_q.size() > 0);
    @(posedge clk);
    m_wrap = 1'b0;
    if (m_busy) begin
      p = msg_q.size() + DIG;
      if (stop) begin
        m_busy = 1'b0;
      end else if (!pause) begin
        act++;
        if ((act % TDIV == 0) && (((act / TDIV) % p) == 0)) m_wrap = 1'b1;
      end
    end else begin
      if (clear) msg_q.delete();
      else if (wr_en && msg_q.size() < DEPTH) msg_q.push_back(wr_char);
      if (start_ok) begin
        m_busy = 1'b1;
        act    = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic write_char(input logic [7:0] c);
    wr_en = 1'b1; wr_char = c;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic load_help();
    clear = 1'b1; cycle(); clear = 1'b0;
    write_char(8'h48); write_char(8'h45); write_char(8'h4C); write_char(8'h50);
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    cycle(); cycle();
    checks++; if (chars !== BLANK) begin errors++; $display("FAIL reset_chars got=%h exp=%h", chars, BLANK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    rst_n = 1'b1;
    model_reset();
    cycle();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_scroll();
    logic [31:0] exp;
    int wraps;
    load_help();
    checks++; if (chars !== 32'h48454C50) begin errors++; $display("FAIL load_first got=%h exp=48454c50", chars); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b exp=1", busy); end
    wraps = 0;
    for (int i = 1; i <= 33; i++) begin
      cycle();
      exp = model_chars();
      checks++; if (chars !== exp) begin errors++; $display("FAIL scroll_chars step=%0d got=%h exp=%h", i, chars, exp); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL scroll_wrap step=%0d got=%b exp=%b", i, wrap, m_wrap); end
      if (wrap === 1'b1) wraps++;
      if (i == 4) begin
        checks++; if (chars !== 32'h454C5020) begin errors++; $display("FAIL first_step got=%h exp=454c5020", chars); end
      end
      if (i == 32) begin
        checks++; if (chars !== 32'h48454C50 || wrap !== 1'b1) begin errors++; $display("FAIL wrap_point got=%h/%b exp=48454c50/1", chars, wrap); end
      end
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", wraps); end
    stop = 1'b1; cycle(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || chars !== BLANK) begin errors++; $display("FAIL stop_idle got=%b/%h exp=0/%h", busy, chars, BLANK); end
    $display("test_load_scroll done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full();
    logic [31:0] exp;
    clear = 1'b1; cycle(); clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_char(8'($urandom_range(33, 126)));
      checks++; if (full !== (i >= 15)) begin errors++; $display("FAIL full_flag write=%0d got=%b exp=%b", i + 1, full, (i >= 15)); end
    end
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i <= (DEPTH + DIG) * TDIV; i++) begin
      exp = model_chars();
      checks++; if (chars !== exp || wrap !== m_wrap) begin errors++; $display("FAIL full_scroll step=%0d got=%h/%b exp=%h/%b", i, chars, wrap, exp, m_wrap); end
      cycle();
    end
    stop = 1'b1; cycle(); stop = 1'b0;
    clear = 1'b1; wr_en = 1'b1; wr_char = 8'h41; cycle(); idle_inputs();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL clear_full got=%b exp=0", full); end
    $display("test_full done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_start_empty();
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      cycle();
      checks++; if (busy !== 1'b0 || chars !== BLANK) begin errors++; $display("FAIL start_empty cyc=%0d got=%b/%h exp=0/%h", i, busy, chars, BLANK); end
    end
    start = 1'b0;
    $display("test_start_empty done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_pause();
    logic [31:0] held;
    load_help();
    cycle(); cycle();
    held = model_chars();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (chars !== held) begin errors++; $display("FAIL pause_frozen cyc=%0d got=%h exp=%h", i, chars, held); end
    end
    pause = 1'b0;
    cycle();
    checks++; if (chars !== 32'h48454C50) begin errors++; $display("FAIL pause_resume1 got=%h exp=48454c50", chars); end
    cycle();
    checks++; if (chars !== 32'h454C5020) begin errors++; $display("FAIL pause_resume2 got=%h exp=454c5020", chars); end
    checks++; if (chars !== model_chars()) begin errors++; $display("FAIL pause_model got=%h exp=%h", chars, model_chars()); end
    stop = 1'b1; cycle(); stop = 1'b0;
    $display("test_pause done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stop_tick();
    logic [31:0] exp;
    load_help();
    for (int i = 1; i <= 31; i++) begin
      wr_en = (i <= 5); wr_char = 8'h5A;
      cycle();
    end
    wr_en = 1'b0;
    stop = 1'b1; cycle(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_tick_busy got=%b exp=0", busy); end
    checks++; if (chars !== BLANK) begin errors++; $display("FAIL stop_tick_chars got=%h exp=%h", chars, BLANK); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL stop_tick_wrap got=%b exp=0", wrap); end
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      cycle();
      exp = model_chars();
      checks++; if (chars !== exp || wrap !== m_wrap) begin errors++; $display("FAIL restart step=%0d got=%h/%b exp=%h/%b", i, chars, wrap, exp, m_wrap); end
    end
    stop = 1'b1; cycle(); stop = 1'b0;
    $display("test_stop_tick done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int n;
    for (int r = 0; r < 4; r++) begin
      clear = 1'b1; cycle(); clear = 1'b0;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_char(8'($urandom_range(33, 126)));
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 100; i++) begin
        pause   = ($urandom_range(0, 3) == 0);
        stop    = ($urandom_range(0, 29) == 0);
        start   = ($urandom_range(0, 9) == 0);
        wr_en   = ($urandom_range(0, 4) == 0);
        wr_char = 8'($urandom_range(33, 126));
        cycle();
        exp = model_chars();
        checks++; if (chars !== exp) begin errors++; $display("FAIL rand_chars r=%0d i=%0d got=%h exp=%h", r, i, chars, exp); end
        checks++; if (wrap !== m_wrap || busy !== m_busy) begin errors++; $display("FAIL rand_flags r=%0d i=%0d got=%b%b exp=%b%b", r, i, wrap, busy, m_wrap, m_busy); end
        checks++; if (full !== model_full()) begin errors++; $display("FAIL rand_full r=%0d i=%0d got=%b exp=%b", r, i, full, model_full()); end
      end
      idle_inputs();
      stop = 1'b1; cycle(); stop = 1'b0;
    end
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    load_help();
    for (int i = 0; i < 6; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (chars !== BLANK) begin errors++; $display("FAIL midrst_chars got=%h exp=%h", chars, BLANK); end
    checks++; if (busy !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%b%b exp=00", busy, wrap); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", full); end
    model_reset();
    #2 rst_n = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    checks++; if (busy !== 1'b0 || chars !== BLANK) begin errors++; $display("FAIL midrst_start got=%b/%h exp=0/%h", busy, chars, BLANK); end
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", busy); end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_load_scroll();
    test_full();
    test_start_empty();
    test_pause();
    test_stop_tick();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
